// File: rtl/sonic_mac_pause_pkg.sv
// Shared definitions for the 10G MAC pause-quanta controller: FSM encoding,
// datapath-specific quantum length and pause-quanta width.
package sonic_mac_pause_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    PAUSED = 2'd2
  } pause_state_t;

  // One 512-bit-time quantum on the 64-bit datapath.
  localparam int QUANTUM_CYCLES_64B = 8;

  localparam int QUANTA_W = 16;

endpackage

// File: rtl/sonic_pause_quanta_timer.sv
// Pause timer: a per-quantum prescaler feeding a quanta down-counter.
// Priority is clear > load > run; the prescaler sits at 0 whenever not running.
module sonic_pause_quanta_timer
  import sonic_mac_pause_pkg::*;
#(
  parameter int QUANTUM_CYCLES = QUANTUM_CYCLES_64B
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [QUANTA_W-1:0] load_val,
  input  logic                run,
  input  logic                clear,
  output logic [QUANTA_W-1:0] remaining,
  output logic                expire
);

  localparam int PS_W = $clog2(QUANTUM_CYCLES);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(QUANTUM_CYCLES - 1);

  logic [PS_W-1:0] prescaler;
  logic            wrap;

  assign wrap   = run && (prescaler == PS_LAST);
  assign expire = wrap && (remaining == QUANTA_W'(1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prescaler <= '0;
      remaining <= '0;
    end else if (load) begin
      prescaler <= '0;
      remaining <= load_val;
    end else if (run) begin
      if (wrap) begin
        prescaler <= '0;
        // Saturate at zero so a stray run can never wrap the count.
        if (remaining != '0) begin
          remaining <= remaining - QUANTA_W'(1);
        end
      end else begin
        prescaler <= prescaler + PS_W'(1);
      end
    end else begin
      prescaler <= '0;
    end
  end

endmodule

// File: rtl/sonic_pcs_eth_10g_mac_pause_quanta_ctrl.sv
// 802.3x pause controller: consumes received pause quanta and gates new TX
// frame starts until the pause expires, draining any frame already in flight.
module sonic_pcs_eth_10g_mac_pause_quanta_ctrl
  import sonic_mac_pause_pkg::*;
#(
  parameter int QUANTUM_CYCLES = QUANTUM_CYCLES_64B,
  parameter int PCNT_W         = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_pause_en,
  input  logic                pauselen_valid,
  input  logic [QUANTA_W-1:0] pauselen_data,
  output logic                pauselen_ready,
  input  logic                tx_frame_active,
  input  logic                tx_start_req,
  output logic                tx_start_gnt,
  output logic                tx_allow,
  output logic                tx_paused,
  output logic [QUANTA_W-1:0] quanta_remaining,
  output logic [PCNT_W-1:0]   pause_count
);

  pause_state_t        state;
  pause_state_t        state_next;
  logic                accept;
  logic                accept_nonzero;
  logic                accept_zero;
  logic                timer_load;
  logic                timer_clear;
  logic                timer_run;
  logic                timer_expire;
  logic [QUANTA_W-1:0] timer_remaining;

  assign accept         = pauselen_valid && cfg_pause_en;
  assign accept_nonzero = accept && (pauselen_data != '0);
  assign accept_zero    = accept && (pauselen_data == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A new pause always replaces the old one, even on the terminal-count cycle.
  always_comb begin
    state_next = state;
    if (!cfg_pause_en) begin
      state_next = IDLE;
    end else if (accept_nonzero) begin
      state_next = tx_frame_active ? DRAIN : PAUSED;
    end else if (accept_zero) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        DRAIN:   if (!tx_frame_active) state_next = PAUSED;
        PAUSED:  if (timer_expire) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    timer_clear  = !cfg_pause_en || accept_zero;
    timer_load   = accept_nonzero;
    timer_run    = (state == PAUSED);
    tx_start_gnt = tx_start_req && tx_allow;
  end

  sonic_pause_quanta_timer #(
    .QUANTUM_CYCLES (QUANTUM_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_val  (pauselen_data),
    .run       (timer_run),
    .clear     (timer_clear),
    .remaining (timer_remaining),
    .expire    (timer_expire)
  );

  assign quanta_remaining = timer_remaining;

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pauselen_ready <= 1'b0;
      tx_allow       <= 1'b0;
      tx_paused      <= 1'b0;
    end else begin
      pauselen_ready <= 1'b1;
      tx_allow       <= (state_next == IDLE);
      tx_paused      <= (state_next == DRAIN) || (state_next == PAUSED);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pause_count <= '0;
    end else if (accept_nonzero && (pause_count != {PCNT_W{1'b1}})) begin
      pause_count <= pause_count + PCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sonic_pcs_eth_10g_mac_pause_quanta_ctrl.sv
// Self-checking bench: directed pause scenarios plus randomized traffic, all
// compared every cycle against a cycle-count reference model of the pause rules.
module tb_sonic_pcs_eth_10g_mac_pause_quanta_ctrl;

  localparam int QC = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_pause_en;
  logic        pauselen_valid;
  logic [15:0] pauselen_data;
  logic        tx_frame_active;
  logic        tx_start_req;

  logic        pauselen_ready;
  logic        tx_start_gnt;
  logic        tx_allow;
  logic        tx_paused;
  logic [15:0] quanta_remaining;
  logic [31:0] pause_count;

  logic        s_ready;
  logic        s_gnt;
  logic        s_allow;
  logic        s_paused;
  logic [15:0] s_quanta;
  logic [1:0]  s_count;

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  // Reference model: mode 0 = free, 1 = waiting for frame end, 2 = timing.
  int          m_mode;
  int unsigned m_loaded;
  int unsigned m_ticks;
  logic [31:0] m_count;
  int          m_count_small;
  logic        m_ready;
  logic        m_allow;
  logic        m_paused;
  logic [15:0] m_quanta;

  always #5 clk = ~clk;

  sonic_pcs_eth_10g_mac_pause_quanta_ctrl #(
    .QUANTUM_CYCLES (QC),
    .PCNT_W         (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_pause_en     (cfg_pause_en),
    .pauselen_valid   (pauselen_valid),
    .pauselen_data    (pauselen_data),
    .pauselen_ready   (pauselen_ready),
    .tx_frame_active  (tx_frame_active),
    .tx_start_req     (tx_start_req),
    .tx_start_gnt     (tx_start_gnt),
    .tx_allow         (tx_allow),
    .tx_paused        (tx_paused),
    .quanta_remaining (quanta_remaining),
    .pause_count      (pause_count)
  );

  // Narrow statistics counter so saturation is reachable quickly.
  sonic_pcs_eth_10g_mac_pause_quanta_ctrl #(
    .QUANTUM_CYCLES (QC),
    .PCNT_W         (2)
  ) dut_small (
    .clk              (clk),
    .reset            (reset),
    .cfg_pause_en     (cfg_pause_en),
    .pauselen_valid   (pauselen_valid),
    .pauselen_data    (pauselen_data),
    .pauselen_ready   (s_ready),
    .tx_frame_active  (tx_frame_active),
    .tx_start_req     (tx_start_req),
    .tx_start_gnt     (s_gnt),
    .tx_allow         (s_allow),
    .tx_paused        (s_paused),
    .quanta_remaining (s_quanta),
    .pause_count      (s_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_mode        = 0;
      m_loaded      = 0;
      m_ticks       = 0;
      m_count       = 32'd0;
      m_count_small = 0;
      m_ready       = 1'b0;
    end else begin
      m_ready = 1'b1;
      if (!cfg_pause_en) begin
        m_mode = 0;
      end else if (pauselen_valid && pauselen_data != 16'd0) begin
        m_loaded = pauselen_data;
        m_ticks  = 0;
        m_mode   = tx_frame_active ? 1 : 2;
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
        if (m_count_small < 3) m_count_small++;
      end else if (pauselen_valid) begin
        m_mode = 0;
      end else if (m_mode == 1) begin
        if (!tx_frame_active) m_mode = 2;
      end else if (m_mode == 2) begin
        m_ticks++;
        if (m_ticks >= m_loaded * QC) m_mode = 0;
      end
    end
    m_allow  = !reset && (m_mode == 0);
    m_paused = !reset && (m_mode != 0);
    m_quanta = (m_mode == 0) ? 16'd0 : 16'(m_loaded - m_ticks / QC);
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("ready",    pauselen_ready,   m_ready);
      checkOutput("allow",    tx_allow,         m_allow);
      checkOutput("paused",   tx_paused,        m_paused);
      checkOutput("quanta",   quanta_remaining, m_quanta);
      checkOutput("count",    pause_count,      m_count);
      checkOutput("gnt",      tx_start_gnt,     tx_start_req & m_allow);
      checkOutput("count_s2", s_count,          m_count_small);
    end
  end

  task automatic applyStimulus(input logic en, input logic valid, input logic [15:0] data,
                               input logic active, input logic req);
    cfg_pause_en    = en;
    pauselen_valid  = valid;
    pauselen_data   = data;
    tx_frame_active = active;
    tx_start_req    = req;
    @(posedge clk);
    #1;
    pauselen_valid  = 1'b0;
  endtask

  // Samples the grant before stepping, so consecutive calls tally blocked cycles.
  task automatic stepCount(input logic valid, input logic [15:0] data, input logic active,
                           inout int blocked);
    if (!tx_start_gnt) blocked++;
    applyStimulus(1'b1, valid, data, active, 1'b1);
  endtask

  initial begin
    int          blocked;
    logic [31:0] base;
    reset = 1'b1;
    cfg_pause_en = 1'b1;
    pauselen_valid = 1'b0;
    pauselen_data = 16'd0;
    tx_frame_active = 1'b0;
    tx_start_req = 1'b0;

    @(posedge clk);
    #1;
    checking = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("allow_rel", tx_allow, 32'd1);
    checkOutput("ready_rel", pauselen_ready, 32'd1);

    // Plain pause of 3 quanta with the scheduler requesting continuously.
    base = m_count;
    applyStimulus(1'b1, 1'b1, 16'd3, 1'b0, 1'b1);
    blocked = 0;
    repeat (40) stepCount(1'b0, 16'd0, 1'b0, blocked);
    checkOutput("blocked_3q", blocked, 32'd24);
    checkOutput("cnt_3q", pause_count, base + 32'd1);

    // Frame in flight around the accept: drain first, then 2 quanta.
    blocked = 0;
    repeat (4) stepCount(1'b0, 16'd0, 1'b1, blocked);
    blocked = 0;
    applyStimulus(1'b1, 1'b1, 16'd2, 1'b1, 1'b1);
    repeat (5) stepCount(1'b0, 16'd0, 1'b1, blocked);
    checkOutput("drain_q", quanta_remaining, 32'd2);
    repeat (40) stepCount(1'b0, 16'd0, 1'b0, blocked);
    checkOutput("blocked_drain", blocked, 32'd22);

    // Reload 5 -> 2 after 12 cycles.
    base = m_count;
    applyStimulus(1'b1, 1'b1, 16'd5, 1'b0, 1'b1);
    blocked = 0;
    repeat (11) stepCount(1'b0, 16'd0, 1'b0, blocked);
    stepCount(1'b1, 16'd2, 1'b0, blocked);
    repeat (40) stepCount(1'b0, 16'd0, 1'b0, blocked);
    checkOutput("blocked_reload", blocked, 32'd28);
    checkOutput("cnt_reload", pause_count, base + 32'd2);

    // XON (zero quanta) mid-pause, then pause disabled mid-pause.
    base = m_count;
    applyStimulus(1'b1, 1'b1, 16'd5, 1'b0, 1'b1);
    repeat (10) applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'd0, 1'b0, 1'b1);
    checkOutput("xon_allow", tx_allow, 32'd1);
    checkOutput("xon_quanta", quanta_remaining, 32'd0);
    checkOutput("xon_cnt", pause_count, base + 32'd1);
    applyStimulus(1'b1, 1'b1, 16'd4, 1'b0, 1'b1);
    repeat (5) applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
    checkOutput("dis_allow", tx_allow, 32'd1);
    checkOutput("dis_quanta", quanta_remaining, 32'd0);

    // Reload landing exactly on the terminal count of a 1-quantum pause.
    applyStimulus(1'b1, 1'b1, 16'd1, 1'b0, 1'b1);
    repeat (7) applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'd4, 1'b0, 1'b1);
    checkOutput("tc_paused", tx_paused, 32'd1);
    checkOutput("tc_quanta", quanta_remaining, 32'd4);
    blocked = 0;
    repeat (40) stepCount(1'b0, 16'd0, 1'b0, blocked);
    checkOutput("blocked_tc", blocked, 32'd32);
    checkOutput("sat_small", s_count, 32'd3);

    // Randomized traffic including occasional resets and long pauses.
    for (int i = 0; i < 3000; i++) begin
      int          r;
      logic [15:0] d;
      logic        act;
      r = $urandom_range(0, 9);
      if (r == 0) d = 16'd0;
      else if (r == 9) d = 16'hFFFF;
      else d = 16'($urandom_range(1, 6));
      act = tx_frame_active;
      if ($urandom_range(0, 15) == 0) act = ~act;
      reset = ($urandom_range(0, 499) == 0);
      applyStimulus($urandom_range(0, 63) != 0, $urandom_range(0, 19) == 0, d, act,
                    1'($urandom_range(0, 1)));
    end
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
